// File: rtl/afu_clk_div_mgr_if.sv
// Control and status bundle for the AFU clock-divider manager.
// The master side programs the ratios and watches the divided clocks and lock status.
interface afu_clk_div_mgr_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic                    div_load;
  logic [NUM_CH-1:0]       outclk;
  logic [NUM_CH-1:0]       clk_en;
  logic                    locked;
  logic                    rst_out_n;

  modport master (
    output div_ratio, div_load,
    input  outclk, clk_en, locked, rst_out_n
  );

  modport slave (
    input  div_ratio, div_load,
    output outclk, clk_en, locked, rst_out_n
  );
endinterface

// File: rtl/afu_clk_div_mgr.sv
// Multi-channel clock divider with settle/lock tracking and downstream reset release.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RESET  | internal reset active or just released; channels held clear
// S_SETTLE | dividers running, settle counter counting toward lock
// S_LOCKED | settle window complete; locked = 1
module afu_clk_div_mgr #(
  parameter int NUM_CH          = 2,
  parameter int DIV_W           = 8,
  parameter int DEFAULT_DIV     = 2,
  parameter int LOCK_CYCLES     = 16,
  parameter int RESET_ON_RELOAD = 1
) (
  input  logic               clk,
  input  logic               resetb,
  afu_clk_div_mgr_if.slave   bus
);

  localparam int                CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  logic [1:0]        r_sync;
  logic              w_rst_n;
  state_t            r_state;
  logic [CNT_W-1:0]  r_settle;
  logic              r_locked;
  logic              r_rst_out_n;
  logic [DIV_W-1:0]  r_ratio [NUM_CH];
  logic [DIV_W-1:0]  r_cnt   [NUM_CH];
  logic [NUM_CH-1:0] r_outclk;
  logic [NUM_CH-1:0] r_clk_en;
  logic              w_run;
  logic              w_load;

  // Internal reset asserts with resetb and releases two edges later.
  assign w_rst_n = r_sync[1];
  assign w_run   = (r_state != S_RESET);
  assign w_load  = bus.div_load && w_run;

  // Two-flop reset synchroniser, async assert / sync release
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  end

  // Sequencing FSM with settle counter and registered lock flag
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_RESET;
      r_settle <= '0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state  <= S_SETTLE;
          r_settle <= '0;
          r_locked <= 1'b0;
        end
        S_SETTLE: begin
          // A load on the terminal cycle restarts the window instead of locking.
          if (bus.div_load) begin
            r_settle <= '0;
          end else if (r_settle == TERM) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_settle <= r_settle + CNT_W'(1);
          end
        end
        S_LOCKED: begin
          if (bus.div_load) begin
            r_state  <= S_SETTLE;
            r_settle <= '0;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_RESET;
          r_settle <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Downstream reset follows lock, optionally sticky once released
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                  r_rst_out_n <= 1'b0;
    else if (RESET_ON_RELOAD != 0) r_rst_out_n <= r_locked;
    else                           r_rst_out_n <= r_rst_out_n | r_locked;
  end

  // Ratio shadows and per-channel divider counters; a load realigns all phases
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ratio[i] <= DIV_W'(DEFAULT_DIV);
        r_cnt[i]   <= '0;
      end
      r_outclk <= '0;
      r_clk_en <= '0;
    end else if (!w_run || w_load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        if (w_load) r_ratio[i] <= bus.div_ratio[i*DIV_W +: DIV_W];
      end
      r_outclk <= '0;
      r_clk_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_ratio[i] == '0) begin
          r_cnt[i]    <= '0;
          r_outclk[i] <= 1'b0;
          r_clk_en[i] <= 1'b0;
        end else if (r_cnt[i] == r_ratio[i] - DIV_W'(1)) begin
          r_cnt[i]    <= '0;
          r_clk_en[i] <= 1'b1;
          r_outclk[i] <= ~r_outclk[i];
        end else begin
          r_cnt[i]    <= r_cnt[i] + DIV_W'(1);
          r_clk_en[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.outclk    = r_outclk;
  assign bus.clk_en    = r_clk_en;
  assign bus.locked    = r_locked;
  assign bus.rst_out_n = r_rst_out_n;

endmodule

// File: tb/tb_afu_clk_div_mgr.sv
// Bench for afu_clk_div_mgr: two instances (reload-reset on and off) share one stimulus
// and are compared every cycle against an edge-count model, plus literal pins.
module tb_afu_clk_div_mgr;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;
  localparam int DEFDIV = 2;
  localparam int LOCK   = 16;

  logic                    clk = 1'b0;
  logic                    resetb = 1'b0;
  logic                    div_load = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_ratio = 16'h0202;

  int checks = 0;
  int errors = 0;
  int ek = -1;

  afu_clk_div_mgr_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus1 ();
  afu_clk_div_mgr_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus0 ();

  assign bus1.div_ratio = div_ratio;
  assign bus1.div_load  = div_load;
  assign bus0.div_ratio = div_ratio;
  assign bus0.div_load  = div_load;

  afu_clk_div_mgr #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFDIV),
                    .LOCK_CYCLES(LOCK), .RESET_ON_RELOAD(1)) dut1 (
    .clk(clk), .resetb(resetb), .bus(bus1));

  afu_clk_div_mgr #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFDIV),
                    .LOCK_CYCLES(LOCK), .RESET_ON_RELOAD(0)) dut0 (
    .clk(clk), .resetb(resetb), .bus(bus0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t ek=%0d: got %0h expected %0h", name, $time, ek, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks edges since resetb went high, the edge where the current settle window
  // (and channel phase) started, and the active ratios. Outputs follow from arithmetic.
  int m_hi = 0;
  int m_edge = 0;
  int m_start = 0;
  bit m_run = 1'b0;
  bit m_locked = 1'b0;
  bit m_rst1 = 1'b0;
  bit m_rst0 = 1'b0;
  int m_ratio [NUM_CH];

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_hi = 0; m_run = 1'b0; m_locked = 1'b0; m_rst1 = 1'b0; m_rst0 = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_ratio[c] = DEFDIV;
    end else begin
      bit prev;
      prev = m_locked;
      m_edge++;
      m_hi++;
      if (!m_run) begin
        if (m_hi == 3) begin
          m_run = 1'b1;
          m_start = m_edge;
        end
      end else if (div_load) begin
        m_start = m_edge;
        for (int c = 0; c < NUM_CH; c++) m_ratio[c] = int'(div_ratio[c*DIV_W +: DIV_W]);
      end
      m_rst1 = prev;
      m_rst0 = m_rst0 | prev;
      m_locked = m_run && ((m_edge - m_start) >= LOCK);
    end
  end

  function automatic logic [NUM_CH-1:0] exp_vec(input bit want_clk);
    logic [NUM_CH-1:0] v;
    int k, r;
    v = '0;
    if (m_run) begin
      k = m_edge - m_start;
      for (int c = 0; c < NUM_CH; c++) begin
        r = m_ratio[c];
        if (r > 0 && k >= r) begin
          if (want_clk) v[c] = ((k / r) % 2) == 1;
          else          v[c] = (k % r) == 0;
        end
      end
    end
    return v;
  endfunction

  // Cycle-by-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #2;
    chk("m_outclk1", bus1.outclk, exp_vec(1'b1));
    chk("m_clken1",  bus1.clk_en, exp_vec(1'b0));
    chk("m_locked1", bus1.locked, m_locked);
    chk("m_rst1",    bus1.rst_out_n, m_rst1);
    chk("m_outclk0", bus0.outclk, exp_vec(1'b1));
    chk("m_clken0",  bus0.clk_en, exp_vec(1'b0));
    chk("m_locked0", bus0.locked, m_locked);
    chk("m_rst0",    bus0.rst_out_n, m_rst0);
  end

  // ---------------- directed stimulus with literal pins ----------------
  task automatic step();
    @(negedge clk);
    ek++;
  endtask

  task automatic step_to(input int target);
    while (ek < target) step();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_outclk1"}, bus1.outclk, 2'b00);
    chk({tag, "_clken1"},  bus1.clk_en, 2'b00);
    chk({tag, "_locked1"}, bus1.locked, 1'b0);
    chk({tag, "_rst1"},    bus1.rst_out_n, 1'b0);
    chk({tag, "_outclk0"}, bus0.outclk, 2'b00);
    chk({tag, "_clken0"},  bus0.clk_en, 2'b00);
    chk({tag, "_locked0"}, bus0.locked, 1'b0);
    chk({tag, "_rst0"},    bus0.rst_out_n, 1'b0);
  endtask

  // Called at a negedge; the next posedge is E0.
  task automatic poweron();
    resetb = 1'b1;
    ek = -1;
    step_to(4);
    chk("po_e4_outclk", bus1.outclk, 2'b11);
    chk("po_e4_clken",  bus1.clk_en, 2'b11);
    step_to(5);
    chk("po_e5_outclk", bus1.outclk, 2'b11);
    chk("po_e5_clken",  bus1.clk_en, 2'b00);
    step_to(6);
    chk("po_e6_outclk", bus1.outclk, 2'b00);
    chk("po_e6_clken",  bus1.clk_en, 2'b11);
    step_to(17);
    chk("po_e17_locked", bus1.locked, 1'b0);
    step_to(18);
    chk("po_e18_locked", bus1.locked, 1'b1);
    chk("po_e18_rst1",   bus1.rst_out_n, 1'b0);
    chk("po_e18_rst0",   bus0.rst_out_n, 1'b0);
    step_to(19);
    chk("po_e19_rst1",   bus1.rst_out_n, 1'b1);
    chk("po_e19_rst0",   bus0.rst_out_n, 1'b1);
  endtask

  task automatic load(input logic [NUM_CH*DIV_W-1:0] ratios, output int l_edge);
    div_ratio = ratios;
    div_load = 1'b1;
    step();
    l_edge = ek;
    div_load = 1'b0;
  endtask

  initial begin
    int l, l2, l3;

    repeat (3) @(negedge clk);
    all_zero("rst");

    poweron();

    // Reload {ch1=5, ch0=3} from S_LOCKED
    step_to(25);
    load(16'h0503, l);
    chk("r35_L_locked", bus1.locked, 1'b0);
    chk("r35_L_outclk", bus1.outclk, 2'b00);
    chk("r35_L_clken",  bus1.clk_en, 2'b00);
    chk("r35_L_rst1",   bus1.rst_out_n, 1'b1);
    step_to(l + 1);
    chk("r35_L1_rst1",  bus1.rst_out_n, 1'b0);
    chk("r35_L1_rst0",  bus0.rst_out_n, 1'b1);
    step_to(l + 3);
    chk("r35_L3_clken", bus1.clk_en, 2'b01);
    step_to(l + 5);
    chk("r35_L5_clken", bus1.clk_en, 2'b10);
    step_to(l + 6);
    chk("r35_L6_clken", bus1.clk_en, 2'b01);
    step_to(l + 15);
    chk("r35_L15_clken",  bus1.clk_en, 2'b11);
    chk("r35_L15_outclk", bus1.outclk, 2'b11);
    chk("r35_L15_locked", bus1.locked, 1'b0);
    step_to(l + 16);
    chk("r35_L16_locked", bus1.locked, 1'b1);
    chk("r35_L16_locked0", bus0.locked, 1'b1);
    chk("r35_L16_rst1",   bus1.rst_out_n, 1'b0);
    chk("r35_L16_rst0",   bus0.rst_out_n, 1'b1);
    step_to(l + 17);
    chk("r35_L17_rst1",   bus1.rst_out_n, 1'b1);

    // Ratio 1 on channel 0, ratio 0 (disabled) on channel 1
    step_to(l + 25);
    load(16'h0001, l);
    step_to(l + 1);
    chk("r10_L1_clken",  bus1.clk_en, 2'b01);
    chk("r10_L1_outclk", bus1.outclk, 2'b01);
    step_to(l + 2);
    chk("r10_L2_clken",  bus1.clk_en, 2'b01);
    chk("r10_L2_outclk", bus1.outclk, 2'b00);
    step_to(l + 3);
    chk("r10_L3_outclk", bus1.outclk, 2'b01);

    // Load on the settle terminal cycle, then again mid-settle
    step_to(l + 30);
    load(16'h0403, l);
    step_to(l + 15);
    chk("term_L15_locked", bus1.locked, 1'b0);
    load(16'h0403, l2);
    chk("term_edge", l2 - l, 16);
    chk("term_locked", bus1.locked, 1'b0);
    chk("term_outclk", bus1.outclk, 2'b00);
    step_to(l2 + 4);
    load(16'h0403, l3);
    step_to(l3 + 15);
    chk("mid_L15_locked", bus1.locked, 1'b0);
    step_to(l3 + 16);
    chk("mid_L16_locked", bus1.locked, 1'b1);

    // Asynchronous reset pulse mid-operation
    step_to(l3 + 20);
    chk("pre_rst_locked", bus1.locked, 1'b1);
    resetb = 1'b0;
    #1;
    all_zero("async");
    @(negedge clk);
    poweron();
    step_to(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/afu_clk_div_mgr.md
# afu_clk_div_mgr

Multi-channel clock-divider and reset-sequencing manager for the AFU clock domain. Derives NUM_CH divided clocks and matching single-cycle clock-enable strobes from the AFU clock, each with a runtime-programmable ratio. Reports a `locked` status once the dividers have run for a settle window, and releases a synchronised downstream reset after lock. This block replaces fixed-ratio PLL wrapping for engine clocking: reconfiguration takes effect without a reset, and lock drops during a ratio change.

## Interface
- NUM_CH, 2: number of divider channels (1..8).
- DIV_W, 8: width of each ratio field.
- DEFAULT_DIV, 2: ratio loaded into every channel at reset.
- LOCK_CYCLES, 16: settle-window length in clk cycles (≥1).
- RESET_ON_RELOAD, 1: if 1, `rst_out_n` drops during a reload settle window; if 0, it stays high.

- clk  in  1  AFU clock; all logic is on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- div_ratio  in  NUM_CH*DIV_W  per-channel ratio; channel i uses bits [i*DIV_W +: DIV_W].
- div_load  in  1  one-cycle strobe that samples div_ratio into the shadow registers.
- outclk  out  NUM_CH  divided square-wave clocks, registered.
- clk_en  out  NUM_CH  one-cycle enable strobes, registered.
- locked  out  1  high once the dividers are stable with the current ratios.
- rst_out_n  out  1  synchronised active-low reset for downstream logic.

## Operation
- Reset synchroniser:
  - resetb low asserts the internal reset immediately (asynchronous).
  - Deassertion passes through a 2-flop synchroniser.
  - Reset values: all outputs 0; ratio registers = DEFAULT_DIV; state = S_RESET.
- State machine:
  - S_RESET: entered on internal reset. Exits to S_SETTLE on the first edge with the synchronised reset released; settle counter = 0.
  - S_SETTLE: settle counter increments each cycle. When it reaches LOCK_CYCLES-1 → S_LOCKED.
  - S_LOCKED: `locked`=1. A div_load returns the block to S_SETTLE with the counter at 0.
  - div_load in S_SETTLE restarts the counter at 0.
  - div_load on the same cycle as the terminal count: the load wins and the block stays in S_SETTLE.
  - div_load in S_RESET is ignored.
- Channel i, ratio r (r taken from the shadow register):
  - r=0: channel disabled; outclk[i]=0, clk_en[i]=0, counter held at 0.
  - r≥1: counter cycles 0..r-1. clk_en[i] is 1 for exactly the cycle after the counter equals r-1. outclk[i] toggles on that same edge.
  - r=1: clk_en[i] is constantly 1 and outclk has a period of 2 clk cycles.
  - In general, outclk period = 2r cycles with 50% duty; clk_en period = r cycles.
- On a div_load edge:
  - All channel counters, outclk and clk_en clear to 0.
  - The new ratios apply from the next cycle, so all channels restart phase-aligned.
- Channels run in S_SETTLE and S_LOCKED. They are held cleared in S_RESET.
- rst_out_n:
  - Registered copy of `locked` (one-cycle lag).
  - With RESET_ON_RELOAD=0, once rst_out_n has risen it stays 1 until resetb is asserted.
- Counter widths: channel counters are DIV_W bits; the settle counter is $clog2(LOCK_CYCLES+1) bits. No wrap beyond the terminal count.

## Timing
- Edge E0 is the first clk edge with resetb high.
  - Synchronised reset releases at E1.
  - S_SETTLE is entered at E2.
  - locked rises at E(LOCK_CYCLES+2).
  - rst_out_n rises at E(LOCK_CYCLES+3).
- Reload: div_load sampled high at edge L.
  - locked=0 from L.
  - Channels are cleared at L.
  - locked rises again at L+LOCK_CYCLES.
  - With RESET_ON_RELOAD=1, rst_out_n falls at L+1 and rises at L+LOCK_CYCLES+1.
- First clk_en after a clear on a channel with ratio r occurs at the r-th edge after the clear.
- resetb assertion mid-operation: every output is 0 asynchronously, with no waiting for clk. Ratios revert to DEFAULT_DIV.

## Test plan
- Power-on, LOCK_CYCLES=16, defaults → outclk[0]/[1] period 4 cycles; locked rises at E18; rst_out_n rises at E19.
- Load ratios {3,5} in S_LOCKED → locked drops at L and recovers at L+16. clk_en[0] fires every 3 cycles, clk_en[1] every 5 cycles. Both outclks are 0 at L and phase-aligned.
- Ratio 0 on channel 1, ratio 1 on channel 0 → outclk[1] and clk_en[1] stay 0; clk_en[0] is constantly 1; outclk[0] toggles every cycle.
- div_load on the settle terminal cycle, and again mid-settle → locked stays 0 until 16 cycles after the last load.
- resetb pulsed low for 1 cycle mid-operation → all outputs 0 immediately; ratios back to 2; full power-on sequence repeats.
- RESET_ON_RELOAD=0 reload → rst_out_n stays 1 throughout while locked drops and recovers.
